imem_arbiter: RTL and testbench

- Shares the single-port, 1024-word, 32-bit instruction memory between two requesters:
  - the pipeline fetch stage (F), which only reads;
  - the program loader/debug port (L), which reads and writes.
- Arbitrates per cycle, drives the memory port and returns read data with fixed 1-cycle latency.
- Supports a loader lock for uninterrupted program download.
- Sits between the IF stage, the loader and the instruction memory.

---
 rtl/imem_arb_pkg.sv | 25 ++
 rtl/imem_arb_stats.sv | 28 ++
 rtl/imem_arbiter.sv | 150 +++++++++++++++
 tb/tb_imem_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Read by imem_arbiter and by imem_arb_stats, which is built only with IMEM_ARB_STATS_EN.
package imem_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    ARB,
    LOCK
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_F,
    OWN_L
  } owner_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/imem_arb_stats.sv
// Saturating event counters for the arbiter. The top instantiates this block
// only when IMEM_ARB_STATS_EN is defined.
module imem_arb_stats
  import imem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_f,
  input  logic        inc_l,
  input  logic        inc_c,
  output logic [31:0] stat_f_grants,
  output logic [31:0] stat_l_grants,
  output logic [31:0] stat_conflicts
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_f_grants  <= '0;
      stat_l_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_f_grants  <= sat_inc(stat_f_grants, inc_f);
      stat_l_grants  <= sat_inc(stat_l_grants, inc_l);
      stat_conflicts <= sat_inc(stat_conflicts, inc_c);
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the fetch stage and the loader onto one single-port instruction memory.
// Defining IMEM_ARB_STATS_EN adds the grant and conflict counter outputs.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W:0]   l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_lock,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_f_grants,
  output logic [31:0]       stat_l_grants,
  output logic [31:0]       stat_conflicts
`endif
);

  state_e            state_q;
  logic              ptr_l_q;   // 1: loader wins the next tie
  owner_e            owner_q;   // who receives the response this cycle
  logic              zero_q;    // response is forced to zero (bad address)
  logic [DATA_W-1:0] f_rdata_q;
  logic [DATA_W-1:0] l_rdata_q;

  logic f_bad;
  logic held;

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    f_bad = (f_addr[1:0] != 2'b00) || (f_addr[31:ADDR_W+2] != '0);
    held  = (state_q == LOCK) && l_lock;

    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (held) begin
      l_gnt = l_req;
    end else if (f_req && l_req) begin
      // The cycle that leaves LOCK arbitrates with the pointer already back on fetch.
      if ((state_q == ARB) && ptr_l_q) l_gnt = 1'b1;
      else                             f_gnt = 1'b1;
    end else begin
      f_gnt = f_req;
      l_gnt = l_req;
    end

    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt && !f_bad) begin
      mem_en   = 1'b1;
      mem_addr = f_addr[ADDR_W+1:2];
    end else if (l_gnt && !l_addr[ADDR_W]) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr[ADDR_W-1:0];
      mem_wdata = l_wdata;
    end
  end

  assign f_rvalid = (owner_q == OWN_F);
  assign f_err    = f_rvalid && zero_q;
  assign l_rvalid = (owner_q == OWN_L);

  // Read data comes straight from the memory in the response cycle, else holds.
  always_comb begin
    f_rdata = f_rdata_q;
    l_rdata = l_rdata_q;
    if (owner_q == OWN_F) f_rdata = zero_q ? DATA_W'(NOP_INSTR) : mem_rdata;
    if (owner_q == OWN_L) l_rdata = zero_q ? '0 : mem_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB;
      ptr_l_q   <= 1'b0;
      owner_q   <= OWN_NONE;
      zero_q    <= 1'b0;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      if (owner_q == OWN_F) f_rdata_q <= f_rdata;
      if (owner_q == OWN_L) l_rdata_q <= l_rdata;

      owner_q <= OWN_NONE;
      zero_q  <= 1'b0;
      if (f_gnt) begin
        owner_q <= OWN_F;
        zero_q  <= f_bad;
      end else if (l_gnt && !l_we) begin
        owner_q <= OWN_L;
        zero_q  <= l_addr[ADDR_W];
      end

      case (state_q)
        ARB: begin
          if (l_gnt && l_lock) begin
            state_q <= LOCK;
            ptr_l_q <= 1'b0;
          end else if (f_gnt) begin
            ptr_l_q <= 1'b1;
          end else if (l_gnt) begin
            ptr_l_q <= 1'b0;
          end
        end
        LOCK: begin
          if (!l_lock) begin
            state_q <= ARB;
            ptr_l_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef IMEM_ARB_STATS_EN
  imem_arb_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .inc_f          (f_gnt),
    .inc_l          (l_gnt),
    .inc_c          (f_req && (l_req || held)),
    .stat_f_grants  (stat_f_grants),
    .stat_l_grants  (stat_l_grants),
    .stat_conflicts (stat_conflicts)
  );
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level reference model of the arbitration rules.
module tb_imem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              f_req = 1'b0;
  logic [31:0]       f_addr = '0;
  logic              f_gnt, f_rvalid, f_err;
  logic [DATA_W-1:0] f_rdata;
  logic              l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [ADDR_W:0]   l_addr = '0;
  logic [DATA_W-1:0] l_wdata = '0;
  logic              l_gnt, l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0] stat_f_grants, stat_l_grants, stat_conflicts;
`endif

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_gnt     (f_gnt),
    .f_rvalid  (f_rvalid),
    .f_rdata   (f_rdata),
    .f_err     (f_err),
    .l_req     (l_req),
    .l_we      (l_we),
    .l_addr    (l_addr),
    .l_wdata   (l_wdata),
    .l_lock    (l_lock),
    .l_gnt     (l_gnt),
    .l_rvalid  (l_rvalid),
    .l_rdata   (l_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    ,
    .stat_f_grants  (stat_f_grants),
    .stat_l_grants  (stat_l_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  // Behavioural single-port memory: unwritten words return a fixed address hash.
  function automatic logic [31:0] init_word(input int a);
    return (32'h9E37_79B9 * (a + 1)) ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] bench_mem [1024];
  bit          bench_wr  [1024];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        bench_mem[mem_addr] <= mem_wdata;
        bench_wr[mem_addr]  <= 1'b1;
      end else begin
        mem_rdata <= bench_wr[mem_addr] ? bench_mem[mem_addr] : init_word(int'(mem_addr));
      end
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [1024];
  logic        m_locked, m_prio_l;
  logic        gf, gl, held, fbad;
  logic        e_en, e_we;
  logic [9:0]  e_addr;
  logic [31:0] e_wd;
  logic        exp_fv, exp_fe, exp_lv;
  logic [31:0] exp_fd, exp_ld, last_fd, last_ld;
  int unsigned cnt_f, cnt_l, cnt_c;

  int n_cmp  = 0;
  int n_fail = 0;

  logic        obs_fgnt, obs_men;
  logic [9:0]  obs_maddr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_prio_l = 1'b0;
    exp_fv = 1'b0; exp_fe = 1'b0; exp_lv = 1'b0;
    exp_fd = '0; exp_ld = '0; last_fd = '0; last_ld = '0;
    cnt_f = 0; cnt_l = 0; cnt_c = 0;
    gf = 1'b0; gl = 1'b0;
  endtask

  // Who gets the memory this cycle, and what the port must look like.
  task automatic model_eval();
    held = m_locked && l_lock;
    if (held) begin
      gf = 1'b0;
      gl = l_req;
    end else if (f_req && l_req) begin
      gl = !m_locked && m_prio_l;
      gf = !gl;
    end else begin
      gf = f_req;
      gl = l_req;
    end
    fbad = (f_addr[1:0] != 2'b00) || (f_addr[31:12] != 20'd0);
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    if (gf && !fbad) begin
      e_en   = 1'b1;
      e_addr = f_addr[11:2];
    end
    if (gl && !l_addr[10]) begin
      e_en   = 1'b1;
      e_we   = l_we;
      e_addr = l_addr[9:0];
      e_wd   = l_wdata;
    end
  endtask

  task automatic model_update();
    if (exp_fv) last_fd = exp_fd;
    if (exp_lv) last_ld = exp_ld;
    exp_fv = gf;
    exp_fe = fbad;
    exp_fd = fbad ? 32'h0 : ref_mem[f_addr[11:2]];
    exp_lv = gl && !l_we;
    exp_ld = l_addr[10] ? 32'h0 : ref_mem[l_addr[9:0]];
    if (gl && l_we && !l_addr[10]) ref_mem[l_addr[9:0]] = l_wdata;
    cnt_f += 32'(gf);
    cnt_l += 32'(gl);
    if (f_req && (l_req || held)) cnt_c++;
    if (held) begin
      m_locked = 1'b1;
    end else if (m_locked) begin
      m_locked = 1'b0;
      m_prio_l = 1'b0;
    end else if (gl && l_lock) begin
      m_locked = 1'b1;
      m_prio_l = 1'b0;
    end else if (gf) begin
      m_prio_l = 1'b1;
    end else if (gl) begin
      m_prio_l = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("f_gnt",     f_gnt,     gf);
    check("l_gnt",     l_gnt,     gl);
    check("mem_en",    mem_en,    e_en);
    check("mem_we",    mem_we,    e_we);
    check("mem_addr",  mem_addr,  e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("f_rvalid",  f_rvalid,  exp_fv);
    check("f_err",     f_err,     exp_fv && exp_fe);
    check("f_rdata",   f_rdata,   exp_fv ? exp_fd : last_fd);
    check("l_rvalid",  l_rvalid,  exp_lv);
    check("l_rdata",   l_rdata,   exp_lv ? exp_ld : last_ld);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_f_gnt"},    f_gnt,    1'b0);
    check({tag, "_l_gnt"},    l_gnt,    1'b0);
    check({tag, "_mem_en"},   mem_en,   1'b0);
    check({tag, "_f_rvalid"}, f_rvalid, 1'b0);
    check({tag, "_f_err"},    f_err,    1'b0);
    check({tag, "_f_rdata"},  f_rdata,  32'h0);
    check({tag, "_l_rvalid"}, l_rvalid, 1'b0);
    check({tag, "_l_rdata"},  l_rdata,  32'h0);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    model_eval();
    compare_all();
    obs_fgnt  = f_gnt;
    obs_men   = mem_en;
    obs_maddr = mem_addr;
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [31:0] rand_faddr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return $urandom;
    if (r == 1) return {20'd0, 5'd0, 5'($urandom_range(0, 31)), 2'b01};
    return {20'd0, 5'd0, 5'($urandom_range(0, 31)), 2'b00};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    int fg_cnt;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;

    // Round-robin under conflict, pointer starts on fetch.
    f_req = 1'b1; f_addr = 32'h40;
    l_req = 1'b1; l_we = 1'b0; l_addr = 11'd9;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_f_gnt", obs_fgnt, (i % 2) == 0);
    end
    f_req = 1'b0; l_req = 1'b0;
    step();

    // Preload word 5 via the loader, then a lone fetch of byte 0x14.
    l_req = 1'b1; l_we = 1'b1; l_addr = 11'd5; l_wdata = 32'h8C02_0004;
    step();
    l_req = 1'b0; l_we = 1'b0;
    f_req = 1'b1; f_addr = 32'h14;
    step();
    check("fetch_gnt", obs_fgnt, 1'b1);
    check("fetch_mem_addr", obs_maddr, 10'd5);
    f_req = 1'b0;
    check("fetch_rvalid", f_rvalid, 1'b1);
    check("fetch_rdata", f_rdata, 32'h8C02_0004);
    check("fetch_err", f_err, 1'b0);
    step();

    // Locked download of words 0..7 while fetch waits on byte 0x1C.
    f_req = 1'b1; f_addr = 32'h1C;
    l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
    fg_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      l_addr  = 11'(i);
      l_wdata = 32'hAAAA_0000 + 32'(i);
      step();
      fg_cnt += int'(obs_fgnt);
    end
    check("lock_f_starved", fg_cnt, 0);
    l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0;
    step();
    check("unlock_f_gnt", obs_fgnt, 1'b1);
    f_req = 1'b0;
    check("unlock_f_rvalid", f_rvalid, 1'b1);
    check("unlock_f_rdata", f_rdata, 32'hAAAA_0007);
    step();

    // Address errors.
    f_req = 1'b1; f_addr = 32'h2;
    step();
    check("misalign_mem_en", obs_men, 1'b0);
    f_req = 1'b0;
    check("misalign_err", f_err, 1'b1);
    check("misalign_rdata", f_rdata, 32'h0);
    f_req = 1'b1; f_addr = 32'h1000;
    step();
    f_req = 1'b0;
    check("range_err", f_err, 1'b1);
    l_req = 1'b1; l_we = 1'b1; l_addr = 11'd1024; l_wdata = 32'hDEAD_BEEF;
    step();
    check("l_oor_wr_mem_en", obs_men, 1'b0);
    l_we = 1'b0;
    step();
    l_req = 1'b0;
    check("l_oor_rd_rvalid", l_rvalid, 1'b1);
    check("l_oor_rd_rdata", l_rdata, 32'h0);
    step();

    // Reset while a fetch response is in flight.
    f_req = 1'b1; f_addr = 32'h14;
    @(negedge clk);
    model_eval();
    compare_all();
    rst = 1'b0;
    f_req = 1'b0;
    #1;
    check_idle_outputs("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    f_req = 1'b1; f_addr = 32'h8;
    l_req = 1'b1; l_we = 1'b0; l_addr = 11'd3;
    step();
    check("post_rst_ptr_f", obs_fgnt, 1'b1);
    f_req = 1'b0; l_req = 1'b0;
    step();
    step();

    // Random traffic with requesters holding their request until granted.
    for (int c = 0; c < 400; c++) begin
      if (!f_req || gf) begin
        f_req  = ($urandom_range(0, 99) < 55);
        f_addr = rand_faddr();
      end
      if (!l_req || gl) begin
        l_req   = ($urandom_range(0, 99) < 45);
        l_we    = 1'($urandom_range(0, 1));
        l_addr  = ($urandom_range(0, 9) == 0) ? {1'b1, 10'($urandom)}
                                               : 11'($urandom_range(0, 31));
        l_wdata = $urandom;
      end
      l_lock = m_locked ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      step();
    end
    f_req = 1'b0; l_req = 1'b0; l_lock = 1'b0;
    step();
    step();

`ifdef IMEM_ARB_STATS_EN
    check("stat_f_grants",  stat_f_grants,  cnt_f);
    check("stat_l_grants",  stat_l_grants,  cnt_l);
    check("stat_conflicts", stat_conflicts, cnt_c);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
